// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port feeding decode.
// Requests are read combinationally from the word array at the accepting
// edge and land in a 2-entry response FIFO. Every head output comes
// straight from a flop, so there is no combinational path from req_addr
// to rsp_*. The image is written at run time through the prog_* port.
// Misaligned or out-of-range fetches return NOP_INSTR with rsp_err set.
// flush (branch redirect) drops everything buffered.
module instr_mem_fetch #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    // fetch request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    // fetch response (buffer head)
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    // redirect
    input  logic              flush,
    // run-time programming
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // One buffered response: word, echoed byte address and error flag.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } entry_t;

    logic [DATA_W-1:0] mem [DEPTH];

    entry_t            head_q;
    entry_t            tail_q;
    entry_t            new_entry;
    logic              head_vld_q;
    logic              tail_vld_q;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  prog_idx;
    logic              req_err;
    logic              push;
    logic              pop;
    logic              prog_wr;

    // The programming port ignores the byte offset and wraps on the upper
    // bits. Fold them here so the intent is explicit.
    logic              unused_prog_bits;
    assign unused_prog_bits = ^{prog_addr[ADDR_W-1:IDX_W+2], prog_addr[1:0]};

    // Word index and error detection for the incoming fetch. DEPTH is a
    // power of two, so "word address >= DEPTH" is the same as any bit set
    // above the index field.
    assign req_idx  = req_addr[IDX_W+1:2];
    assign req_err  = (req_addr[1:0] != 2'b00) | (|req_addr[ADDR_W-1:IDX_W+2]);
    assign prog_idx = prog_addr[IDX_W+1:2];

    // Room exists when the tail slot is free, or when the head leaves in
    // this same cycle. Reset, flush and programming all block new fetches.
    assign req_ready = ~rst & ~flush & ~prog_en & (~tail_vld_q | rsp_ready);
    assign push      = req_valid & req_ready;
    assign pop       = head_vld_q & rsp_ready;
    assign prog_wr   = prog_en & ~rst & ~flush;

    // Build the entry that a fetch accepted this cycle would write into the buffer.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        new_entry      = '0;
        new_entry.addr = req_addr;
        new_entry.err  = req_err;
        new_entry.data = req_err ? NOP_INSTR : mem[req_idx];
    end

    // Word array write port. A write on one edge is visible to a fetch
    // accepted on the next edge.
    always_ff @(posedge clk) begin
        // NOTE: the word array is deliberately left out of reset. The image survives rst, and an array reset cannot map onto RAM.
        if (prog_wr) begin
            mem[prog_idx] <= prog_data;
        end
    end

    // Two-entry in-order response FIFO. Priority: rst, then flush, then push/pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_q     <= '0;
        end else if (flush) begin
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    // Head leaves and a new entry arrives. The occupancy does not change.
                    if (tail_vld_q) begin
                        head_q <= tail_q;
                        tail_q <= new_entry;
                    end else begin
                        head_q <= new_entry;
                    end
                end
                2'b10: begin
                    if (head_vld_q) begin
                        tail_q     <= new_entry;
                        tail_vld_q <= 1'b1;
                    end else begin
                        head_q     <= new_entry;
                        head_vld_q <= 1'b1;
                    end
                end
                2'b01: begin
                    // Advance the tail only if it holds data. Otherwise the
                    // head keeps its last contents while rsp_valid drops.
                    if (tail_vld_q) begin
                        head_q <= tail_q;
                    end
                    head_vld_q <= tail_vld_q;
                    tail_vld_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Head outputs are driven directly by flops.
    assign rsp_valid = head_vld_q;
    assign rsp_data  = head_q.data;
    assign rsp_addr  = head_q.addr;
    assign rsp_err   = head_q.err;

endmodule

// File: tb/tb_instr_mem_fetch.sv
`timescale 1ns/1ps
// Directed bench for instr_mem_fetch. When a stimulus task sees its fetch
// accepted, it queues the hand-computed response. A monitor pops the queue
// and compares on every response handshake.
module tb_instr_mem_fetch;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] W0    = 32'h00500093;
    localparam logic [31:0] W1    = 32'h00a00113;
    localparam logic [31:0] W2    = 32'h002081b3;
    localparam logic [31:0] W3    = 32'h40208233;
    localparam logic [31:0] W8    = 32'h00c00293;
    localparam logic [31:0] W1023 = 32'h0000006f;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cycle = 0;

    instr_mem_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_en   (prog_en),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor. It samples at the falling edge, between launch edges.
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got addr %h data %h, required no response", rsp_addr, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                check("rsp_err",  64'(rsp_err),  64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch and wait for it to be accepted. Once accepted, queue the expected response.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            exp_q.push_back('{data: d, addr: a, err: e});
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_timeout: addr %h never accepted, required acceptance", a);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_en   = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rsp_valid) break;
            tick();
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        check({tag, "_rsp_addr"},  64'(rsp_addr),  64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int c0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;

        // Power-on reset: two reset edges.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("por_req_ready_in_rst", 64'(req_ready), 64'd0);
            check("por_rsp_valid_in_rst", 64'(rsp_valid), 64'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("por");
        tick();

        // Load the image.
        prog(32'h0000_0000, W0);
        prog(32'h0000_0004, W1);
        prog(32'h0000_0008, W2);
        prog(32'h0000_000c, W3);
        prog(32'h0000_0020, W8);
        prog(32'h0000_0ffc, W1023);

        // Reset with stale entries buffered.
        rsp_ready = 1'b0;
        fetch(32'h0, W0, 1'b0);
        fetch(32'h4, W1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        tick();
        drain();

        // Streaming: four back-to-back fetches with the consumer always ready.
        rsp_ready = 1'b1;
        c0 = cycle;
        fetch(32'h0, W0, 1'b0);
        fetch(32'h4, W1, 1'b0);
        fetch(32'h8, W2, 1'b0);
        fetch(32'hc, W3, 1'b0);
        check("stream_cycles", 64'(cycle - c0), 64'd4);
        drain();

        // Latency: one cycle from acceptance into an empty buffer.
        rsp_ready = 1'b1;
        fetch(32'hc, W3, 1'b0);
        @(negedge clk);
        check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lat_rsp_addr",  64'(rsp_addr),  64'hc);
        tick();
        @(negedge clk);
        check("lat_rsp_valid_after", 64'(rsp_valid), 64'd0);
        tick();

        // Backpressure: the third fetch stalls while full, then enters in the pop cycle.
        rsp_ready = 1'b0;
        fetch(32'h0, W0, 1'b0);
        fetch(32'h4, W1, 1'b0);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(negedge clk);
        check("bp_req_ready_full", 64'(req_ready), 64'd0);
        check("bp_head_addr",      64'(rsp_addr),  64'h0);
        check("bp_head_data",      64'(rsp_data),  64'(W0));
        tick();
        @(negedge clk);
        check("bp_req_ready_full2", 64'(req_ready), 64'd0);
        check("bp_head_hold_addr",  64'(rsp_addr),  64'h0);
        check("bp_head_hold_data",  64'(rsp_data),  64'(W0));
        tick();
        rsp_ready = 1'b1;
        fetch(32'h8, W2, 1'b0);
        drain();

        // Error responses plus the last legal word.
        rsp_ready = 1'b1;
        fetch(32'h0000_0006, NOP, 1'b1);
        fetch(32'h0000_1000, NOP, 1'b1);
        fetch(32'h0000_0ffc, W1023, 1'b0);
        fetch(32'hffff_fffc, NOP, 1'b1);
        drain();

        // Flush: two entries are buffered and a request is pending.
        rsp_ready = 1'b0;
        fetch(32'h0, W0, 1'b0);
        fetch(32'h4, W1, 1'b0);
        req_valid = 1'b1;
        req_addr  = 32'hc;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        rsp_ready = 1'b1;
        fetch(32'h20, W8, 1'b0);
        drain();

        // Programming: fetches blocked, buffered entry drains, new data visible next cycle.
        rsp_ready = 1'b0;
        fetch(32'h0, W0, 1'b0);
        req_valid = 1'b1;
        req_addr  = 32'h10;
        prog_en   = 1'b1;
        prog_addr = 32'h10;
        prog_data = 32'hdeadbeef;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("prog_req_ready", 64'(req_ready), 64'd0);
        tick();
        prog_en = 1'b0;
        fetch(32'h10, 32'hdeadbeef, 1'b0);
        prog(32'h0000_1010, 32'hcafef00d);
        fetch(32'h10, 32'hcafef00d, 1'b0);
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
